// File: rtl/bcd_carry_counter.sv
// Two-digit BCD cascade counter, modulo MODULO, with checked synchronous preset and a combinational carry.
// Optional down-count with a `dir` port is compiled in when BCD_CNT_DOWN_EN is defined.
module bcd_carry_counter #(
  parameter int unsigned MODULO    = 60,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
`ifdef BCD_CNT_DOWN_EN
  input  logic       dir,
`endif
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic       cout,
  output logic       load_err
);

  localparam logic [3:0] MAX_TENS = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULO - 1) % 10);
  localparam logic [3:0] RST_TENS = 4'(RESET_VAL / 10);
  localparam logic [3:0] RST_ONES = 4'(RESET_VAL % 10);
  localparam logic [6:0] MOD_BIN  = 7'(MODULO);

  logic [3:0] tens_r, ones_r;
  logic [3:0] tens_nxt, ones_nxt;
  logic       err_r, err_nxt;
  logic       at_max, at_zero;
  logic       load_ok;
  logic [6:0] load_dec;
  logic       count_en;
  logic       down;

  assign at_max  = (tens_r == MAX_TENS) && (ones_r == MAX_ONES);
  assign at_zero = (tens_r == 4'd0) && (ones_r == 4'd0);

`ifdef BCD_CNT_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // Decimal value of the preset is only meaningful when both digits are legal.
  assign load_dec = (7'(load_val[7:4]) * 7'd10) + 7'(load_val[3:0]);
  assign load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                    (load_dec < MOD_BIN);

  assign count_en = cin && !load && !rst;
  assign cout     = count_en && (down ? at_zero : at_max);

  always_comb begin
    tens_nxt = tens_r;
    ones_nxt = ones_r;
    err_nxt  = 1'b0;
    if (rst) begin
      tens_nxt = RST_TENS;
      ones_nxt = RST_ONES;
    end else if (load) begin
      if (load_ok) begin
        tens_nxt = load_val[7:4];
        ones_nxt = load_val[3:0];
      end else begin
        err_nxt = 1'b1;
      end
    end else if (cin) begin
      if (down) begin
        if (at_zero) begin
          tens_nxt = MAX_TENS;
          ones_nxt = MAX_ONES;
        end else if (ones_r == 4'd0) begin
          ones_nxt = 4'd9;
          tens_nxt = tens_r - 4'd1;
        end else begin
          ones_nxt = ones_r - 4'd1;
        end
      end else begin
        if (at_max) begin
          tens_nxt = 4'd0;
          ones_nxt = 4'd0;
        end else if (ones_r == 4'd9) begin
          ones_nxt = 4'd0;
          tens_nxt = tens_r + 4'd1;
        end else begin
          ones_nxt = ones_r + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    tens_r <= tens_nxt;
    ones_r <= ones_nxt;
    err_r  <= err_nxt;
  end

  assign q_tens   = tens_r;
  assign q_ones   = ones_r;
  assign load_err = err_r;

endmodule

// File: tb/tb_bcd_carry_counter.sv
// Self-checking bench for bcd_carry_counter: per-cycle expected-queue scoreboard plus directed spot checks.
// Down-count vectors run only when BCD_CNT_DOWN_EN is defined.
module tb_bcd_carry_counter;

  localparam int MOD  = 60;
  localparam int RVAL = 0;

  logic       clk;
  logic       rst;
  logic       cin;
  logic       dir;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] q_tens, q_ones;
  logic       cout;
  logic       load_err;

  int checks;
  int errors;
  int cout_seen;
  int m_val;
  logic m_err;

  // {q_tens, q_ones, cout, load_err}
  logic [9:0] exp_q[$];

  bcd_carry_counter #(.MODULO(MOD), .RESET_VAL(RVAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .cin      (cin),
`ifdef BCD_CNT_DOWN_EN
    .dir      (dir),
`endif
    .load     (load),
    .load_val (load_val),
    .q_tens   (q_tens),
    .q_ones   (q_ones),
    .cout     (cout),
    .load_err (load_err)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic use_down();
`ifdef BCD_CNT_DOWN_EN
    use_down = dir;
`else
    use_down = 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, push the expected outputs for that cycle, advance the model
  task automatic step(input logic r, input logic ld, input logic [7:0] lv, input logic c);
    logic exp_cout;
    logic [3:0] lt, lo;
    int ldec;
    rst = r; load = ld; load_val = lv; cin = c;
    exp_cout = c && !ld && !r && (use_down() ? (m_val == 0) : (m_val == MOD - 1));
    exp_q.push_back({to_bcd(m_val), exp_cout, m_err});
    #2;
    if (cout === 1'b1) cout_seen++;
    @(posedge clk);
    #1;
    lt = lv[7:4];
    lo = lv[3:0];
    ldec = int'(lt) * 10 + int'(lo);
    if (r) begin
      m_val = RVAL;
      m_err = 1'b0;
    end else if (ld) begin
      if (lt <= 4'd9 && lo <= 4'd9 && ldec < MOD) begin
        m_val = ldec;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (c) begin
        if (use_down()) m_val = (m_val == 0) ? MOD - 1 : m_val - 1;
        else            m_val = (m_val == MOD - 1) ? 0 : m_val + 1;
      end
    end
  endtask

  // monitor: compare DUT outputs mid-cycle against the oldest expected entry
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb", {q_tens, q_ones, cout, load_err}, e);
    end
  end

  initial begin
    int u;
    checks = 0; errors = 0; cout_seen = 0;
    m_val = RVAL; m_err = 1'b0;
    dir = 1'b0;
    rst = 1'b1; cin = 1'b1; load = 1'b1; load_val = 8'h25;
    @(posedge clk);
    #1;

    // reset dominates load and cin, then hold
    step(1, 1, 8'h25, 1);
    step(1, 1, 8'h25, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0);
    check("reset_hold_q", {q_tens, q_ones, 2'b00}, {8'h00, 2'b00});

    // cascade from a mod-12 prescaler
    cout_seen = 0;
    u = 0;
    for (int i = 0; i < 720; i++) begin
      step(0, 0, 8'h00, (u == 11));
      u = (u + 1) % 12;
    end
    check("cascade_q", {q_tens, q_ones, 2'b00}, {8'h00, 2'b00});
    check("cascade_cout_count", 10'(cout_seen), 10'd1);

    // digit rollover
    step(0, 1, 8'h09, 0);
    step(0, 0, 8'h00, 1);
    check("ones_to_tens", {q_tens, q_ones, 2'b00}, {8'h10, 2'b00});
    step(0, 1, 8'h59, 0);
    cout_seen = 0;
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    check("wrap_q", {q_tens, q_ones, 2'b00}, {8'h00, 2'b00});
    check("wrap_cout_once", 10'(cout_seen), 10'd1);

    // illegal presets
    step(0, 1, 8'h60, 0);
    check("err_after_60", {q_tens, q_ones, 1'b0, load_err}, {8'h00, 2'b01});
    step(0, 1, 8'h1A, 0);
    check("err_after_1a", {q_tens, q_ones, 1'b0, load_err}, {8'h00, 2'b01});
    step(0, 0, 8'h00, 0);
    check("err_clears", {9'd0, load_err}, 10'd0);
    step(0, 1, 8'h00, 0);
    check("load_00_ok", {q_tens, q_ones, 1'b0, load_err}, 10'd0);

    // load beats cin at terminal value
    step(0, 1, 8'h59, 0);
    step(0, 1, 8'h30, 1);
    check("load_over_cin", {q_tens, q_ones, 2'b00}, {8'h30, 2'b00});

    // reset mid-count, then back-to-back counting
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    check("reset_mid_count", {q_tens, q_ones, 2'b00}, {8'h00, 2'b00});
    cout_seen = 0;
    for (int i = 0; i < 2 * MOD; i++) step(0, 0, 8'h00, 1);
    check("b2b_cout_count", 10'(cout_seen), 10'd2);
    step(0, 1, 8'h47, 0);
    step(0, 0, 8'h00, 1);
    check("count_47_48", {q_tens, q_ones, 2'b00}, {8'h48, 2'b00});

`ifdef BCD_CNT_DOWN_EN
    dir = 1'b1;
    step(0, 1, 8'h00, 0);
    cout_seen = 0;
    step(0, 0, 8'h00, 1);
    check("down_wrap_q", {q_tens, q_ones, 2'b00}, {8'h59, 2'b00});
    check("down_wrap_cout", 10'(cout_seen), 10'd1);
    step(0, 1, 8'h10, 0);
    step(0, 0, 8'h00, 1);
    check("down_borrow", {q_tens, q_ones, 2'b00}, {8'h09, 2'b00});
    dir = 1'b0;
`endif

    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_carry_counter.md
Name: bcd_carry_counter

Overview:
- Downstream cascade stage for the mod-N binary counter: it consumes that counter's terminal-count output `c` on its `cin` input and counts those events in two BCD digits, modulo MODULO.
- Typical chain is mod-12 prescaler, then this block (mod-60), then further instances chained through `cout` (seconds to minutes to hours).
- It provides synchronous preset with range checking and a combinational carry, so stages cascade in the same cycle.

Parameters:
- MODULO, 60: count modulus. Legal range 2..99. The count runs 0..MODULO-1.
- RESET_VAL, 0: binary value loaded on reset. Must be < MODULO. It is converted to BCD internally.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream counter.
- rst  input  1  synchronous reset, active-high.
- cin  input  1  count enable. This is the upstream terminal-count/carry, one-cycle qualified.
- load  input  1  synchronous preset request.
- load_val  input  8  preset value, packed BCD: [7:4] tens, [3:0] ones.
- q_tens  output  4  BCD tens digit.
- q_ones  output  4  BCD ones digit.
- cout  output  1  carry to the next stage (combinational).
- load_err  output  1  registered one-cycle pulse: a preset was rejected.

Behaviour:
- All state updates on the rising edge of clk. Priority: rst > load > cin.
- Reset:
  - rst=1 at an edge sets {q_tens,q_ones} to BCD(RESET_VAL) and load_err to 0.
  - rst overrides load and cin in the same cycle.
  - cout is forced to 0 while rst=1.
- Count (load=0, cin=1):
  - If value < MODULO-1: ones increments. If ones==9, ones becomes 0 and tens increments.
  - If value == MODULO-1: wraps to 00.
- Hold: cin=0 and load=0 leaves the value unchanged.
- cout:
  - cout = cin & ~load & ~rst & (value == MODULO-1).
  - It is combinational, high in the same cycle as the wrapping edge, and exactly one cycle per wrap.
  - No registered latency, so chained stages advance on the same edge.
- Load (load=1, rst=0):
  - Accepted if both digits are ≤ 9 and the decimal value < MODULO. The value becomes load_val on that edge.
  - Rejected otherwise: the value is unchanged and load_err=1 for the following cycle.
  - A cin asserted in a load cycle is discarded, whether the load is accepted or rejected. cout=0 in that cycle.
- load_err: registered. It is 1 only in the cycle after a rejected load; otherwise 0. It is cleared by rst.
- Digits are never outside 0..9. The value is never ≥ MODULO after reset.
- Reset mid-count: the next value is RESET_VAL regardless of in-flight cin. No spurious cout.
- Back-to-back cin (cin held high) counts every cycle. cout fires once per MODULO cycles.

Optional Feature:
- Macro name: BCD_CNT_DOWN_EN.
- Defined:
  - Adds input port `dir` (1 bit). dir=1 gives down-count; dir=0 gives up-count as above.
  - Down: value 00 with cin wraps to MODULO-1. Otherwise it decrements, with ones 0 borrowing to become 9 and tens decrementing.
  - cout = cin & ~load & ~rst & (dir ? value==00 : value==MODULO-1).
  - Load and reset behaviour are unchanged.
  - dir is sampled only on edges where cin=1.
- Not defined: no `dir` port; up-count only.

Test Plan:
1. Reset and hold:
   - Stimulus: rst=1 for 2 cycles with cin=1 and load=1 (load_val=8'h25), then rst=0, cin=0 for 5 cycles.
   - Response: q=00 throughout; cout=0; load_err=0.
2. Cascade with the mod-12 upstream counter:
   - Stimulus: drive cin from counterN #(12) `c` for 720 upstream cycles.
   - Response: q advances once per 12 clocks; after 60 increments, q=00 and cout pulsed exactly once, in the same cycle as q 59→00.
3. Digit rollover:
   - Stimulus: load 8'h09, then one cin.
   - Response: q=10.
   - Stimulus: load 8'h59, then cin.
   - Response: q=00 and cout=1 in that cycle only.
4. Illegal preset:
   - Stimulus: load 8'h60, then 8'h1A, with MODULO=60.
   - Response: q unchanged; load_err=1 in each following cycle, then 0.
   - Stimulus: load 8'h00.
   - Response: accepted; no error.
5. Simultaneous load and cin:
   - Stimulus: at q=59, assert load=1 (8'h30) and cin=1.
   - Response: q=30; cout=0; no increment.
6. Down-count (BCD_CNT_DOWN_EN defined):
   - Stimulus: dir=1, q=00, cin.
   - Response: q=59 with cout=1.
   - Stimulus: next cin at q=10.
   - Response: q=09.
